// File: rtl/npc_pipe_pkg.sv
// Shared definitions for pipeline stage buffers: skid-buffer state encoding
// and the valid/ready handshake helper reused by every stage buffer.
// No ports; imported with `import npc_pipe_pkg::*;`.
package npc_pipe_pkg;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_BUSY  = 2'd1;
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // The fourth code (2'd3) is unreachable in normal operation and is
  // steered back to EMPTY by the next-state logic.
  typedef enum logic [1:0] {
    ST_EMPTY = SKID_EMPTY,
    ST_BUSY  = SKID_BUSY,
    ST_FULL  = SKID_FULL
  } skid_state_t;

  // A transfer happens only on the cycle both sides agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/ff_d_sr.sv
// Purpose: enabled data register with synchronous active-high reset.
// Latency: 1 cycle (data_in visible on data_out after the edge with wen=1).
// Backpressure: none; holds its value while wen=0.
// Ports: clk, rst (sync, active-high), wen (write enable),
//        data_in / data_out (DATA_LEN bits).
module ff_d_sr #(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_DATA = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [DATA_LEN-1:0] data_in,
  output logic [DATA_LEN-1:0] data_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= RST_DATA;
    end else if (wen) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/pipe_skid_buf.sv
// Purpose: 2-entry skid buffer between a producer stage and a consumer that may stall.
// Latency: 1 cycle from in_fire to out_valid; sustains 1 entry/cycle with out_ready=1.
// Backpressure: in_ready is decoded from registered state only (low only when both
//   entries are held), so no combinational path exists from out_ready to in_ready.
// Ports: clk, rst (sync, active-high), flush (drop all entries),
//        in_valid/in_ready/in_data (producer side),
//        out_valid/out_ready/out_data (consumer side; out_data comes straight from main).
module pipe_skid_buf
  import npc_pipe_pkg::*;
#(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_DATA = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data
);

  skid_state_t         state_q;
  skid_state_t         state_d;
  logic                in_fire;
  logic                out_fire;
  logic                main_wen;
  logic                main_from_skid;
  logic                skid_wen;
  logic [DATA_LEN-1:0] main_din;
  logic [DATA_LEN-1:0] skid_q;

  assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign in_ready  = (state_q != ST_FULL);
  assign in_fire   = hs_fire(in_valid, in_ready);
  assign out_fire  = hs_fire(out_valid, out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_wen       = 1'b0;
    main_from_skid = 1'b0;
    skid_wen       = 1'b0;
    if (flush) begin
      // Redirect: everything buffered or arriving this cycle is discarded;
      // data registers are left alone since they are don't-care when EMPTY.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_BUSY;
            main_wen = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_wen = 1'b1;
          end else if (in_fire) begin
            // Consumer stalled: park the new entry in skid, head stays put.
            state_d  = ST_FULL;
            skid_wen = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can move.
          if (out_fire) begin
            state_d        = ST_BUSY;
            main_wen       = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_din = main_from_skid ? skid_q : in_data;

  ff_d_sr #(.DATA_LEN(DATA_LEN), .RST_DATA(RST_DATA)) main_data (
    .clk      (clk),
    .rst      (rst),
    .wen      (main_wen),
    .data_in  (main_din),
    .data_out (out_data)
  );

  ff_d_sr #(.DATA_LEN(DATA_LEN), .RST_DATA(RST_DATA)) skid_data (
    .clk      (clk),
    .rst      (rst),
    .wen      (skid_wen),
    .data_in  (in_data),
    .data_out (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buf.sv
module tb_pipe_skid_buf;

  localparam int          DW   = 32;
  localparam logic [31:0] RSTD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_buf #(.DATA_LEN(DW), .RST_DATA(RSTD)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic        chk_d;
    logic [31:0] e_d;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] d,
                     input logic ordy, input logic eov, input logic eir,
                     input logic cd, input logic [31:0] ed, input string nm);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = eov; v.e_ir = eir; v.chk_d = cd; v.e_d = ed; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] q[$];
  logic [31:0] seq;
  logic        hold_prev;
  logic [31:0] hold_data;
  logic        ifire, ofire;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // rst flush iv data ordy | out_valid in_ready chk_data data
    // 1: reset
    add(1,0,0,32'h0,0, 0,1,1,RSTD,     "reset0");
    add(1,0,0,32'h0,0, 0,1,1,RSTD,     "reset1");
    add(0,0,0,32'h0,0, 0,1,1,RSTD,     "post_reset");
    // 2: streaming
    add(0,0,1,32'h1,1, 1,1,1,32'h1,    "stream1");
    add(0,0,1,32'h2,1, 1,1,1,32'h2,    "stream2");
    add(0,0,1,32'h3,1, 1,1,1,32'h3,    "stream3");
    add(0,0,1,32'h4,1, 1,1,1,32'h4,    "stream4");
    add(0,0,0,32'h0,1, 0,1,0,32'h0,    "stream_drain");
    // 3: backpressure, 0xA held 5 cycles while new data is offered
    add(0,0,1,32'hA,0, 1,1,1,32'hA,    "bp_push_a");
    add(0,0,1,32'hB,0, 1,0,1,32'hA,    "bp_full");
    for (int i = 0; i < 5; i++)
      add(0,0,1,32'hEE,0, 1,0,1,32'hA, "bp_hold");
    add(0,0,0,32'h0,1, 1,1,1,32'hB,    "bp_pop_a");
    add(0,0,0,32'h0,1, 0,1,0,32'h0,    "bp_pop_b");
    // FULL draining while producer keeps offering: 0xC accepted only once in_ready=1
    add(0,0,1,32'hA,0, 1,1,1,32'hA,    "fd_push_a");
    add(0,0,1,32'hB,0, 1,0,1,32'hA,    "fd_full");
    add(0,0,1,32'hC,1, 1,1,1,32'hB,    "fd_pop_a_no_accept");
    add(0,0,1,32'hC,1, 1,1,1,32'hC,    "fd_pop_b_accept_c");
    add(0,0,0,32'h0,1, 0,1,0,32'h0,    "fd_empty");
    // 4: flush from FULL with an offered 0xC
    add(0,0,1,32'hA,0, 1,1,1,32'hA,    "fl_push_a");
    add(0,0,1,32'hB,0, 1,0,1,32'hA,    "fl_full");
    add(0,1,1,32'hC,0, 0,1,0,32'h0,    "fl_flush_full");
    add(0,0,0,32'h0,1, 0,1,0,32'h0,    "fl_no_c");
    // flush in BUSY drops a same-cycle in_fire
    add(0,0,1,32'h11,0, 1,1,1,32'h11,  "fl_push_11");
    add(0,1,1,32'h22,0, 0,1,0,32'h0,   "fl_flush_busy");
    add(0,0,0,32'h0,1, 0,1,0,32'h0,    "fl_no_22");
    // flush with a simultaneous out_fire
    add(0,0,1,32'h33,0, 1,1,1,32'h33,  "fl_push_33");
    add(0,1,0,32'h0,1, 0,1,0,32'h0,    "fl_flush_ofire");
    // 5: reset while BUSY with in_valid
    add(0,0,1,32'h5,0, 1,1,1,32'h5,    "rst_push_5");
    add(1,0,1,32'h77,0, 0,1,1,RSTD,    "rst_mid");
    add(0,0,0,32'h0,1, 0,1,1,RSTD,     "rst_after");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".out_valid"}, {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      chk({vecs[i].name, ".in_ready"},  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
      if (vecs[i].chk_d) chk({vecs[i].name, ".out_data"}, out_data, vecs[i].e_d);
    end

    // 6: random traffic against a queue scoreboard; buffer is EMPTY here
    q.delete();
    seq = 32'h1000;
    hold_prev = 1'b0;
    hold_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      chk("rnd.out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
      chk("rnd.in_ready",  {31'b0, in_ready},  {31'b0, (q.size() < 2)});
      if (q.size() > 0) chk("rnd.order", out_data, q[0]);
      if (hold_prev) begin
        chk("rnd.stable_valid", {31'b0, out_valid}, 32'd1);
        chk("rnd.stable_data", out_data, hold_data);
      end
      rst       = ($urandom_range(0, 999) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = seq;
      seq       = seq + 1;
      ifire = in_valid & (q.size() < 2);
      ofire = out_ready & (q.size() > 0);
      hold_prev = (q.size() > 0) && !out_ready && !flush && !rst;
      hold_data = (q.size() > 0) ? q[0] : '0;
      if (rst || flush) begin
        q.delete();
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(in_data);
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
